// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous RAM between the instruction-fetch port (I)
//   and the load/store data port (D). One access per cycle; grant is combinational
//   in the request cycle and read data returns one cycle after the grant.
//
//   Build option: MEM_ARB_RR_EN
//     undefined (default): fixed D priority, with a starvation guard that forces an
//                          I grant after STARVE_N consecutive refusals.
//     defined            : round-robin between I and D on contention.
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int STARVE_N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Response FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD_I = 2'd1;
    localparam logic [1:0] ST_RD_D = 2'd2;

    logic [1:0] r_rsp_state;
    logic [1:0] w_nxt_state;
    logic       w_i_win;
    logic       w_d_win;
    logic       w_i_rsp;
    logic       w_d_rsp;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;

`ifdef MEM_ARB_RR_EN
    // Port that won the most recent grant; the other port wins the next tie.
    localparam logic WIN_I = 1'b0;
    localparam logic WIN_D = 1'b1;
    logic r_last_win;
`else
    // Consecutive cycles the fetch port has been refused while requesting.
    localparam int         SW         = $clog2(STARVE_N + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_N);
    logic [SW-1:0] r_starve_cnt;
`endif

    // Arbitration: pick at most one winner; nothing is granted while reset is held.
    always_comb begin
        w_i_win = 1'b0;
        w_d_win = 1'b0;
        if (!rst_n) begin
            w_i_win = 1'b0;
            w_d_win = 1'b0;
        end else if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            if (r_last_win == WIN_D) begin
                w_i_win = 1'b1;
            end else begin
                w_d_win = 1'b1;
            end
`else
            if (r_starve_cnt == STARVE_MAX) begin
                w_i_win = 1'b1;
            end else begin
                w_d_win = 1'b1;
            end
`endif
        end else if (i_req) begin
            w_i_win = 1'b1;
        end else if (d_req) begin
            w_d_win = 1'b1;
        end else begin
            w_i_win = 1'b0;
            w_d_win = 1'b0;
        end
    end

    assign i_gnt     = w_i_win;
    assign d_gnt     = w_d_win;
    assign mem_en    = w_i_win | w_d_win;
    assign mem_we    = w_d_win & d_we;
    assign mem_addr  = w_i_win ? i_addr : (w_d_win ? d_addr : {ADDR_W{1'b0}});
    assign mem_wdata = w_d_win ? d_wdata : {DATA_W{1'b0}};

    // Next response state: a read granted now returns its data next cycle.
    always_comb begin
        w_nxt_state = ST_IDLE;
        if (w_i_win) begin
            w_nxt_state = ST_RD_I;
        end else if (w_d_win && !d_we) begin
            w_nxt_state = ST_RD_D;
        end else begin
            w_nxt_state = ST_IDLE;
        end
    end

    // Response state register; reset drops any in-flight read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_state <= ST_IDLE;
        end else begin
            r_rsp_state <= w_nxt_state;
        end
    end

    // Decode which port receives this cycle's RAM read data.
    always_comb begin
        w_i_rsp = 1'b0;
        w_d_rsp = 1'b0;
        case (r_rsp_state)
            ST_RD_I: w_i_rsp = 1'b1;
            ST_RD_D: w_d_rsp = 1'b1;
            default: begin
                w_i_rsp = 1'b0;
                w_d_rsp = 1'b0;
            end
        endcase
    end

    // Masking with rst_n makes a response vanish in the cycle reset is applied.
    assign i_rvalid = w_i_rsp & rst_n;
    assign d_rvalid = w_d_rsp & rst_n;
    assign i_rdata  = i_rvalid ? mem_rdata : r_i_rdata;
    assign d_rdata  = d_rvalid ? mem_rdata : r_d_rdata;

    // Capture returned words so each rdata holds between responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_i_rdata <= {DATA_W{1'b0}};
            r_d_rdata <= {DATA_W{1'b0}};
        end else begin
            if (w_i_rsp) begin
                r_i_rdata <= mem_rdata;
            end
            if (w_d_rsp) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember the most recent winner for round-robin tie breaking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_win <= WIN_D;
        end else if (w_i_win) begin
            r_last_win <= WIN_I;
        end else if (w_d_win) begin
            r_last_win <= WIN_D;
        end else begin
            r_last_win <= r_last_win;
        end
    end
`else
    // Count refused fetch cycles, saturating; cleared once I is served or drops its request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_cnt <= {SW{1'b0}};
        end else if (!i_req || w_i_win) begin
            r_starve_cnt <= {SW{1'b0}};
        end else if (r_starve_cnt != STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + {{(SW-1){1'b0}}, 1'b1};
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural RAM, reference memory
// image and per-port queues of expected read data.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int SN = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] qi[$];
    logic [DW-1:0] qd[$];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_N(SN)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural single-port synchronous RAM.
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    // Scoreboard: pop responses, then push expectations for this cycle's grants.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_i_gnt", i_gnt, 0);
            check("rst_d_gnt", d_gnt, 0);
            check("rst_mem_en", mem_en, 0);
            check("rst_i_rvalid", i_rvalid, 0);
            check("rst_d_rvalid", d_rvalid, 0);
            qi.delete();
            qd.delete();
        end else begin
            check("gnt_excl", i_gnt & d_gnt, 0);
            check("mem_en", mem_en, i_gnt | d_gnt);
            if (i_rvalid) begin
                if (qi.size() == 0) check("i_rvalid_unexp", 1, 0);
                else check("i_rdata", i_rdata, qi.pop_front());
            end else if (qi.size() != 0) begin
                check("i_rvalid_miss", 0, 1);
                qi.delete();
            end
            if (d_rvalid) begin
                if (qd.size() == 0) check("d_rvalid_unexp", 1, 0);
                else check("d_rdata", d_rdata, qd.pop_front());
            end else if (qd.size() != 0) begin
                check("d_rvalid_miss", 0, 1);
                qd.delete();
            end
            if (i_gnt) begin
                check("i_mem_addr", mem_addr, i_addr);
                check("i_mem_we", mem_we, 0);
                qi.push_back(ref_mem[i_addr]);
            end
            if (d_gnt) begin
                check("d_mem_addr", mem_addr, d_addr);
                check("d_mem_we", mem_we, d_we);
                if (d_we) begin
                    check("d_mem_wdata", mem_wdata, d_wdata);
                    ref_mem[d_addr] = d_wdata;
                end else begin
                    qd.push_back(ref_mem[d_addr]);
                end
            end
        end
    end

    initial begin
        logic exp_i;
        logic i_done;
        logic d_done;
        for (int a = 0; a < (1 << AW); a++) begin
            ram[a]     = 16'(a) ^ 16'h5A5A;
            ref_mem[a] = 16'(a) ^ 16'h5A5A;
        end
        ram[16'h0010]     = 16'hA5A5;
        ref_mem[16'h0010] = 16'hA5A5;

        // Reset with both ports requesting: nothing may be granted.
        rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = 16'h0010; d_addr = 16'h0030; d_wdata = 16'h0000;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Contention from reset with both requests held.
        for (int k = 0; k < 10; k++) begin
            i_addr = 16'h0010 + 16'(k);
            d_addr = 16'h0030 + 16'(k);
            @(negedge clk);
`ifdef MEM_ARB_RR_EN
            exp_i = (k % 2 == 0);
`else
            exp_i = (k % (SN + 1) == SN);
`endif
            check("arb_i_gnt", i_gnt, exp_i);
            check("arb_d_gnt", d_gnt, !exp_i);
            @(posedge clk); #1;
        end

        // Idle: no strobe, zero address and data.
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_mem_en", mem_en, 0);
        check("idle_mem_addr", mem_addr, 0);
        check("idle_mem_wdata", mem_wdata, 0);

        // Fetch only.
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 16'h0010;
        @(negedge clk);
        check("fetch_gnt", i_gnt, 1);
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
        check("fetch_rvalid", i_rvalid, 1);
        check("fetch_rdata", i_rdata, 16'hA5A5);

        // Store then load back-to-back.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
        @(negedge clk);
        check("st_gnt", d_gnt, 1);
        check("st_mem_we", mem_we, 1);
        @(posedge clk); #1;
        d_we = 1'b0;
        @(negedge clk);
        check("ld_gnt", d_gnt, 1);
        check("st_no_rvalid", d_rvalid, 0);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        check("ld_rvalid", d_rvalid, 1);
        check("ld_rdata", d_rdata, 16'h1234);
        @(posedge clk); #1;
        @(negedge clk);
        check("ld_rvalid_off", d_rvalid, 0);
        check("ld_rdata_hold", d_rdata, 16'h1234);

        // Reset in the cycle after a fetch grant drops the response.
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 16'h0010;
        @(negedge clk);
        check("rstrd_gnt", i_gnt, 1);
        @(posedge clk); #1;
        i_req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("rstrd_rvalid_n1", i_rvalid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstrd_i_rvalid_n2", i_rvalid, 0);
        check("rstrd_d_rvalid_n2", d_rvalid, 0);

        // Random traffic; each requester holds until granted.
        i_done = 1'b0; d_done = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 300; c++) begin
            if (i_done) i_req = 1'b0;
            if (d_done) d_req = 1'b0;
            if (!i_req && $urandom_range(0, 1) == 1) begin
                i_req = 1'b1; i_addr = 16'($urandom_range(0, 63));
            end
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = 16'($urandom_range(0, 63)); d_wdata = 16'($urandom);
            end
            @(negedge clk);
            i_done = i_gnt; d_done = d_gnt;
            @(posedge clk); #1;
        end

        // Drain and confirm every expected response arrived.
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("drain_qi", qi.size(), 0);
        check("drain_qd", qd.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
